// File: rtl/pattern_gen.sv
// Streaming pattern generator: drains an AXI-stream FIFO through a one-word holding register onto dout at one word per ckdiv+1 cycles.
// Define PATGEN_TLAST_EN to let a word accepted with tlast end the run once it has been emitted.
module pattern_gen #(
  parameter int size    = 32,
  parameter int max_div = 32,
  parameter int saddr_w = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [size-1:0]            tdata,
  input  logic                       tvalid,
  output logic                       tready,
  input  logic                       tlast,
  input  logic [$clog2(max_div)-1:0] ckdiv,
  input  logic [saddr_w-1:0]         word_count,
  input  logic [size-1:0]            idle_value,
  input  logic                       start,
  input  logic                       abort,
  output logic [size-1:0]            dout,
  output logic                       dout_oe,
  output logic                       ready,
  output logic                       busy,
  output logic                       done,
  output logic                       underrun,
  output logic [saddr_w-1:0]         emitted
);
  localparam int div_w = $clog2(max_div);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [size-1:0]    hold_reg;
  logic               hold_v_reg;
  logic [div_w-1:0]   div_reg;
  logic [div_w-1:0]   ckdiv_reg;
  logic [saddr_w-1:0] count_reg;
  logic [saddr_w-1:0] emitted_reg;
  logic               underrun_reg;
  logic [size-1:0]    dout_reg;

  logic tick;
  logic finished;
  logic accept;
  logic consume;
  logic emit;
  logic starve;
  logic start_go;

  // A word is due when the divider reaches the period latched at the previous wrap.
  assign tick     = (state_reg == S_RUN) && (div_reg == ckdiv_reg);
  assign accept   = tvalid && tready;
  assign consume  = tick && hold_v_reg;
  assign emit     = consume && !finished && !abort;
  assign starve   = tick && !hold_v_reg && !finished && !abort;
  assign start_go = (state_reg == S_IDLE) && start && !abort;

`ifdef PATGEN_TLAST_EN
  logic hold_last_reg;
  logic last_seen_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_last_reg <= 1'b0;
      last_seen_reg <= 1'b0;
    end else begin
      if (accept) hold_last_reg <= tlast;
      if (start_go) last_seen_reg <= 1'b0;
      else if (emit && hold_last_reg) last_seen_reg <= 1'b1;
    end
  end

  assign finished = (emitted_reg == count_reg) || last_seen_reg;
`else
  logic tlast_unused;
  assign tlast_unused = tlast;
  assign finished     = (emitted_reg == count_reg);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = (word_count == '0) ? S_DONE : S_PRIME;
        S_PRIME: if (hold_v_reg) state_next = S_RUN;
        S_RUN:   if (finished) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    tready  = 1'b0;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    dout_oe = 1'b0;
    case (state_reg)
      S_IDLE:  ready = 1'b1;
      S_PRIME: begin
        busy   = 1'b1;
        tready = !hold_v_reg;
      end
      S_RUN: begin
        busy    = 1'b1;
        dout_oe = 1'b1;
        tready  = !hold_v_reg || tick;
      end
      S_DONE:  done = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_reg     <= '0;
      hold_v_reg   <= 1'b0;
      div_reg      <= '0;
      ckdiv_reg    <= '0;
      count_reg    <= '0;
      emitted_reg  <= '0;
      underrun_reg <= 1'b0;
      dout_reg     <= '0;
    end else begin
      if (abort || state_reg == S_DONE) begin
        hold_v_reg <= 1'b0;
      end else if (accept) begin
        hold_v_reg <= 1'b1;
        hold_reg   <= tdata;
      end else if (consume) begin
        hold_v_reg <= 1'b0;
      end

      // Preset to the period so the very first RUN cycle is a tick.
      if (state_reg == S_PRIME && state_next == S_RUN) begin
        div_reg   <= ckdiv;
        ckdiv_reg <= ckdiv;
      end else if (state_reg == S_RUN) begin
        if (tick) begin
          div_reg   <= '0;
          ckdiv_reg <= ckdiv;
        end else begin
          div_reg <= div_reg + 1'b1;
        end
      end else begin
        div_reg <= '0;
      end

      if (start_go) begin
        count_reg    <= word_count;
        emitted_reg  <= '0;
        underrun_reg <= 1'b0;
      end else begin
        if (emit && emitted_reg != '1) emitted_reg <= emitted_reg + 1'b1;
        if (starve) underrun_reg <= 1'b1;
      end

      if (abort || state_next == S_IDLE || state_next == S_DONE) dout_reg <= idle_value;
      else if (emit) dout_reg <= hold_reg;
    end
  end

  assign dout     = dout_reg;
  assign underrun = underrun_reg;
  assign emitted  = emitted_reg;

endmodule

// File: doc/pattern_gen.md
# pattern_gen

Streaming pattern generator: the output-direction counterpart of the capture path. It drains sample words from an AXI-stream FIFO (written by DMA) and drives them onto a parallel output bus at a programmable divided rate, with start/abort control and done/underrun status. It sits between the output FIFO's master side and the pin drivers, on the system clock.

## Interface

- `size`, 32, output bus and stream data width
- `max_div`, 32, maximum clock division; `ckdiv` is `$clog2(max_div)` bits wide
- `saddr_w`, 24, width of word counters
- `clk` in 1: system clock; all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `tdata` in `size`: stream sample word
- `tvalid` in 1: stream word valid
- `tready` out 1: stream word accepted when `tvalid & tready`
- `tlast` in 1: end-of-pattern marker (see Configuration)
- `ckdiv` in `$clog2(max_div)`: one output word every `ckdiv+1` cycles
- `word_count` in `saddr_w`: words to emit per run; sampled on `start`
- `idle_value` in `size`: `dout` value when not running
- `start` in 1: begin a run (honoured in IDLE only)
- `abort` in 1: terminate run immediately
- `dout` out `size`: pattern output
- `dout_oe` out 1: output enable, high in RUN
- `ready` out 1: high in IDLE
- `busy` out 1: high in PRIME or RUN
- `done` out 1: one-cycle pulse on normal completion
- `underrun` out 1: sticky; word due but none held
- `emitted` out `saddr_w`: words emitted in current/last run

## Operation

- Reset values: `dout`=0, `dout_oe`=0, `tready`=0, `ready`=1, `busy`=0, `done`=0, `underrun`=0, `emitted`=0; state IDLE; holding register empty; divider 0.
- One-word holding register `hold`/`hold_v` between the stream and `dout`.
- `tready` = (state PRIME or RUN) and (`!hold_v` or (tick and `hold_v`)). Never high in IDLE/DONE.
- States:
  - IDLE: `dout`=`idle_value`. On `start`: latch `word_count`, clear `emitted` and `underrun`; if `word_count`==0 go DONE, else PRIME.
  - PRIME: wait for first word into `hold`; when `hold_v` set, go RUN with divider preset to `ckdiv` (tick on first RUN cycle).
  - RUN: divider counts 0..`ckdiv`, tick when divider==`ckdiv`, then wraps to 0. At tick with `hold_v`: `dout`<=`hold`, `emitted`++, hold consumed (refilled same cycle if `tvalid`). At tick without `hold_v`: set `underrun`, `dout` holds, divider keeps running, nothing counted. When `emitted` reaches latched count, go DONE.
  - DONE: `done`=1 for exactly one cycle, `dout_oe`=0, `dout`=`idle_value`, flush `hold`; next cycle IDLE.
- `abort` (any state, highest priority): next state IDLE, `hold` flushed, `dout`=`idle_value`, `dout_oe`=0, no `done` pulse; `emitted` keeps its value. Words remaining upstream are not drained.
- `start` outside IDLE ignored; `start` and `abort` together: abort wins, stays IDLE.
- `ckdiv` is sampled each tick; changing it mid-run takes effect at the next wrap.
- `emitted` saturates at all-ones; counters compare at full `saddr_w` width.

## Timing

- `start` at edge N -> PRIME from N+1.
- Word handshake at edge k in PRIME -> RUN at k+1 -> on `dout` after edge k+2 (2-cycle latency); subsequent words every `ckdiv+1` cycles if stream keeps up.
- Last word on `dout` at edge m -> DONE at m+1 (`done` high one cycle, `dout`=`idle_value`) -> IDLE at m+2.
- With `ckdiv`=0 and continuous `tvalid`, one word per cycle, no bubbles.

## Configuration

- `PATGEN_TLAST_EN` defined: a word accepted with `tlast`=1 ends the run after that word is emitted (DONE as for count completion), even if fewer than `word_count` words.
- Undefined: `tlast` ignored; runs end on `word_count` or `abort` only.

## Test plan

- `word_count`=4, `ckdiv`=0, words 0xA0..0xA3 continuously valid -> `dout` A0,A1,A2,A3 on consecutive cycles, first 2 cycles after first handshake; `done` one pulse; `emitted`=4; `underrun`=0.
- `ckdiv`=3, `word_count`=3 -> each word held exactly 4 cycles; `tready` high once per 4 cycles in RUN.
- `ckdiv`=1, `tvalid` dropped for 5 cycles mid-run -> `underrun`=1 and sticky, `dout` holds last word, run resumes and completes with all `word_count` words emitted.
- `abort` asserted after 2 of 8 words -> IDLE next cycle, `dout`=`idle_value`, `dout_oe`=0, no `done`, `emitted`=2; new `start` runs normally.
- `word_count`=0 -> DONE immediately, `done` pulse, zero words consumed (`tready` never high).
- With `PATGEN_TLAST_EN`, `word_count`=10, `tlast` on 3rd word -> 3 words emitted, `done` pulse; without the macro the same stimulus emits 10.
